// File: rtl/reg_readout_if.sv
// Request/acknowledge read port between the scanner and a register bank.
// The master modport issues requests; the slave modport answers with data and ack.
interface reg_readout_if;
  logic       rd_req;
  logic [2:0] rd_addr;
  logic [3:0] rd_data;
  logic       rd_ack;

  modport master (output rd_req, output rd_addr, input rd_data, input rd_ack);
  modport slave  (input rd_req, input rd_addr, output rd_data, output rd_ack);
endinterface

// File: rtl/reg_readout.sv
// Periodically scans NREGS 4-bit registers and drives one active-low 7-segment digit each.
// Define READOUT_TIMEOUT_EN to add a 16-cycle ack timeout with a sticky err flag.
module reg_readout #(
  parameter int NREGS    = 8,
  parameter int SCAN_DIV = 500
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  reg_readout_if.master      rd,
  output logic [8*NREGS-1:0] hex_flat,
  output logic               busy,
  output logic               scan_done,
  output logic               err
);

  localparam int            CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] TICK_MAX = CW'(SCAN_DIV - 1);
  localparam logic [2:0]    LAST_IDX = 3'(NREGS - 1);

  typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      tick_cnt_q, tick_cnt_d;
  logic               tick;
  logic [2:0]         idx_q, idx_d;
  logic [2:0]         rd_addr_q, rd_addr_d;
  logic               rd_req_q, rd_req_d;
  logic               busy_q, busy_d;
  logic               scan_done_q, scan_done_d;
  logic [8*NREGS-1:0] hex_q, hex_d;
  logic               latch;
  logic [7:0]         seg;

`ifdef READOUT_TIMEOUT_EN
  logic [3:0] wait_q, wait_d;
  logic       err_q, err_d;
`endif

  function automatic logic [7:0] decode(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  assign tick = (tick_cnt_q == TICK_MAX);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rd_addr_d   = rd_addr_q;
    hex_d       = hex_q;
    latch       = 1'b0;
    seg         = 8'hFF;
    tick_cnt_d  = tick ? '0 : tick_cnt_q + CW'(1);
`ifdef READOUT_TIMEOUT_EN
    err_d       = err_q;
`endif

    case (state_q)
      IDLE: begin
        // Ticks arriving mid-scan are simply lost; only IDLE looks at them.
        if (tick && en) begin
          state_d   = REQ;
          idx_d     = 3'd0;
          rd_addr_d = 3'd0;
        end
      end
      REQ: begin
        if (rd.rd_ack) begin
          latch = 1'b1;
          seg   = decode(rd.rd_data);
        end
`ifdef READOUT_TIMEOUT_EN
        else if (wait_q == 4'hF) begin
          latch = 1'b1;
          seg   = 8'hBF;
          err_d = 1'b1;
        end
`endif
        if (latch) begin
          state_d = (idx_q == LAST_IDX) ? DONE : GAP;
        end
      end
      GAP: begin
        state_d   = REQ;
        idx_d     = idx_q + 3'd1;
        rd_addr_d = idx_q + 3'd1;
      end
      default: begin
        state_d = IDLE;
        idx_d   = 3'd0;
      end
    endcase

    for (int i = 0; i < NREGS; i++) begin
      if (latch && idx_q == 3'(i)) begin
        hex_d[8*i +: 8] = seg;
      end
    end

    // Outputs are registered, so they are computed from the next state.
    rd_req_d    = (state_d == REQ);
    busy_d      = (state_d != IDLE);
    scan_done_d = (state_d == DONE);
`ifdef READOUT_TIMEOUT_EN
    wait_d      = (state_q == REQ && state_d == REQ) ? wait_q + 4'd1 : 4'd0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      idx_q       <= 3'd0;
      rd_addr_q   <= 3'd0;
      rd_req_q    <= 1'b0;
      busy_q      <= 1'b0;
      scan_done_q <= 1'b0;
      hex_q       <= '1;
`ifdef READOUT_TIMEOUT_EN
      wait_q      <= 4'd0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      idx_q       <= idx_d;
      rd_addr_q   <= rd_addr_d;
      rd_req_q    <= rd_req_d;
      busy_q      <= busy_d;
      scan_done_q <= scan_done_d;
      hex_q       <= hex_d;
`ifdef READOUT_TIMEOUT_EN
      wait_q      <= wait_d;
      err_q       <= err_d;
`endif
    end
  end

  assign rd.rd_req  = rd_req_q;
  assign rd.rd_addr = rd_addr_q;
  assign hex_flat   = hex_q;
  assign busy       = busy_q;
  assign scan_done  = scan_done_q;
`ifdef READOUT_TIMEOUT_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_reg_readout.sv
// Self-checking bench for reg_readout: table vectors, random scans against a
// latency/decode model, plus en gating, stray ack, mid-scan reset and timeout sequences.
module tb_reg_readout;
  localparam int NREGS    = 8;
  localparam int SCAN_DIV = 64;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en  = 1'b0;
  logic [8*NREGS-1:0] hex_flat;
  logic               busy, scan_done, err;

  reg_readout_if rif();

  reg_readout #(.NREGS(NREGS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .rd(rif),
    .hex_flat(hex_flat), .busy(busy), .scan_done(scan_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] bank;
    int          dly;
    logic [63:0] exp_hex;
    int          exp_lat;
  } vec_t;

  vec_t       vecs [4];
  logic [7:0] seg_lut [16];
  logic [3:0] bank [8];
  int         dly [8];
  bit         stray = 1'b0;
  bit         mute_en = 1'b0;
  int         mute_addr = 0;
  logic [3:0] junk = 4'h0;
  int         wcnt = 0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         exp_err = 1'b0;
  int         exp_addr = 0;
  logic       prev_req = 1'b0;
  logic [2:0] prev_addr = 3'd0;

  // Behavioural register bank: acks after dly[addr] wait cycles, junk outside requests.
  always_comb begin
    rif.rd_ack  = stray;
    rif.rd_data = junk;
    if (rif.rd_req === 1'b1) begin
      rif.rd_data = bank[rif.rd_addr];
      rif.rd_ack  = (wcnt >= dly[rif.rd_addr]) && !(mute_en && int'(rif.rd_addr) == mute_addr);
    end
  end

  always @(posedge clk) begin
    if (rif.rd_req !== 1'b1 || rif.rd_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: bound expired, got no event, expected one", name);
  endtask

  // Address order and hold-during-wait monitor.
  always @(negedge clk) begin
    if (rst) begin
      exp_addr = 0;
      prev_req = 1'b0;
    end else begin
      if (rif.rd_req && !prev_req) begin
        check("addr_order", 64'(rif.rd_addr), 64'(exp_addr));
        exp_addr = (exp_addr + 1) % NREGS;
      end else if (rif.rd_req && prev_req) begin
        check("addr_hold", 64'(rif.rd_addr), 64'(prev_addr));
      end
      prev_req  = rif.rd_req;
      prev_addr = rif.rd_addr;
    end
  end

  task automatic check_reset(input string name);
    check({name, " hex"},       hex_flat, {64{1'b1}});
    check({name, " rd_req"},    64'(rif.rd_req), 64'd0);
    check({name, " busy"},      64'(busy), 64'd0);
    check({name, " scan_done"}, 64'(scan_done), 64'd0);
    check({name, " err"},       64'(err), 64'd0);
  endtask

  task automatic load(input logic [31:0] bv, input int d);
    for (int i = 0; i < NREGS; i++) begin
      bank[i] = bv[4*i +: 4];
      dly[i]  = d;
    end
  endtask

  function automatic logic [63:0] model_hex(input logic [31:0] bv);
    logic [63:0] h;
    for (int i = 0; i < NREGS; i++) h[8*i +: 8] = seg_lut[bv[4*i +: 4]];
    return h;
  endfunction

  // Tick-to-scan_done: each REQ lasts wait+1, plus NREGS-1 gaps and the DONE cycle.
  function automatic int model_lat();
    int s = NREGS;
    for (int i = 0; i < NREGS; i++) s += dly[i] + 1;
    return s;
  endfunction

  task automatic count_req(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (rif.rd_req) cnt++;
    end
  endtask

  task automatic run_scan(input string name, input logic [63:0] exp_hex,
                          input int exp_lat, input int drop_at);
    int t0, t1;
    bit got;
    got = 1'b0;
    for (int k = 0; k < 2*SCAN_DIV + 8; k++) begin
      @(negedge clk);
      if (rif.rd_req === 1'b1) begin got = 1'b1; break; end
    end
    if (!got) begin fail_bound({name, " start"}); return; end
    t0 = cyc;
    check({name, " tick_align"}, 64'(t0 % SCAN_DIV), 64'd0);
    check({name, " busy_rise"}, 64'(busy), 64'd1);
    got = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (drop_at >= 0 && rif.rd_req && rif.rd_addr == drop_at[2:0]) en = 1'b0;
      if (scan_done === 1'b1) begin got = 1'b1; break; end
    end
    if (!got) begin fail_bound({name, " scan_done"}); return; end
    t1 = cyc;
    check({name, " latency"}, 64'(t1 - (t0 - 1)), 64'(exp_lat));
    check({name, " busy_at_done"}, 64'(busy), 64'd1);
    @(negedge clk);
    check({name, " done_pulse"}, 64'(scan_done), 64'd0);
    check({name, " busy_fall"}, 64'(busy), 64'd0);
    check({name, " hex"}, hex_flat, exp_hex);
    check({name, " err"}, 64'(err), 64'(exp_err));
  endtask

  initial begin
    logic [31:0] bv;
    logic [63:0] eh;
    int          n;
    bit          got;

    seg_lut = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    vecs[0] = '{32'h76543210, 0, 64'hF8829299B0A4F9C0, 16};
    vecs[1] = '{32'h98FEDCBA, 0, 64'h90808E86A1C68388, 16};
    vecs[2] = '{32'h76543210, 3, 64'hF8829299B0A4F9C0, 40};
    vecs[3] = '{32'hFEDCBA98, 1, 64'h8E86A1C683889080, 24};
    load(32'h0, 0);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    count_req(SCAN_DIV + 4, n);
    check("en_low_no_req", 64'(n), 64'd0);
    en = 1'b1;

    for (int i = 0; i < 4; i++) begin
      load(vecs[i].bank, vecs[i].dly);
      run_scan($sformatf("vec%0d", i), vecs[i].exp_hex, vecs[i].exp_lat, -1);
    end

    // Stray acks in IDLE and GAP with junk data must not touch any digit.
    load(32'h2C5A91E3, 2);
    eh    = model_hex(32'h2C5A91E3);
    stray = 1'b1;
    junk  = 4'h5;
    run_scan("stray", eh, model_lat(), -1);
    repeat (10) begin
      @(negedge clk);
      junk = 4'($urandom);
    end
    check("stray_idle hex", hex_flat, eh);
    stray = 1'b0;

    load(vecs[0].bank, 0);
    run_scan("en_drop", vecs[0].exp_hex, 16, 3);
    count_req(SCAN_DIV + 4, n);
    check("en_drop no_rescan", 64'(n), 64'd0);
    en = 1'b1;

    for (int r = 0; r < 6; r++) begin
      bv = $urandom;
      for (int i = 0; i < NREGS; i++) begin
        bank[i] = bv[4*i +: 4];
        dly[i]  = $urandom_range(0, 3);
      end
      run_scan($sformatf("rand%0d", r), model_hex(bv), model_lat(), -1);
    end

    load(vecs[1].bank, 1);
    got = 1'b0;
    for (int k = 0; k < 2*SCAN_DIV + 8; k++) begin
      @(negedge clk);
      if (rif.rd_req === 1'b1) begin got = 1'b1; break; end
    end
    if (!got) fail_bound("rst_mid start");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    load(vecs[1].bank, 0);
    run_scan("after_rst", vecs[1].exp_hex, 16, -1);

`ifdef READOUT_TIMEOUT_EN
    load(vecs[0].bank, 0);
    mute_en   = 1'b1;
    mute_addr = 5;
    exp_err   = 1'b1;
    run_scan("timeout", 64'hF882BF99B0A4F9C0, 31, -1);
    mute_en = 1'b0;
    run_scan("err_sticky", vecs[0].exp_hex, 16, -1);
    rst = 1'b1;
    @(negedge clk);
    check_reset("err_clear");
    @(negedge clk);
    rst     = 1'b0;
    exp_err = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
